gb_camera_capture: RTL and testbench

- Parametrised Game Boy Camera mapper.
- Extends plain ROM/RAM banking with the A000-A07F camera register file and a timed capture state machine.
- The capture engine pulls a frame from a pixel source and writes it into cart RAM bank 0 at 0x0100-0x0EFF (3584 bytes).
- Sits in the cart mapper slot beside the other MBCs; ROM/cram address outputs feed the shared SDRAM/BRAM paths.

---
 rtl/gb_camera_capture_if.sv | 22 ++
 rtl/gb_camera_capture.sv | 180 ++++++++++++++++++
 tb/tb_gb_camera_capture.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_camera_capture_if.sv
// rtl/gb_camera_capture_if.sv - pixel source and capture write-back channel for the camera mapper
// master = mapper side (requests pixels, issues capture RAM writes); slave = pixel source / RAM arbiter side.
interface gb_camera_capture_if #(
  parameter int RAM_BANK_BITS = 4
);
  logic                       pix_req;
  logic                       pix_valid;
  logic [7:0]                 pix_data;
  logic                       cap_wr;
  logic [RAM_BANK_BITS+12:0]  cap_addr;
  logic [7:0]                 cap_data;

  modport master (
    output pix_req, cap_wr, cap_addr, cap_data,
    input  pix_valid, pix_data
  );

  modport slave (
    input  pix_req, cap_wr, cap_addr, cap_data,
    output pix_valid, pix_data
  );
endinterface

// File: rtl/gb_camera_capture.sv
// rtl/gb_camera_capture.sv - Game Boy Camera mapper: ROM/RAM banking, A000 register file, timed frame capture
// The capture engine streams FRAME_BYTES pixel bytes into RAM bank 0 starting at FRAME_BASE.
module gb_camera_capture #(
  parameter int          ROM_BANK_BITS = 6,
  parameter int          RAM_BANK_BITS = 4,
  parameter int          CAP_BASE      = 32446,
  parameter int          FRAME_BYTES   = 3584,
  parameter logic [12:0] FRAME_BASE    = 13'h0100
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       ce_cpu,
  input  logic [ROM_BANK_BITS-1:0]   rom_mask,
  input  logic [RAM_BANK_BITS-1:0]   ram_mask,
  input  logic [14:0]                cart_addr,
  input  logic                       cart_a15,
  input  logic                       cart_rd,
  input  logic                       cart_wr,
  input  logic [7:0]                 cart_di,
  input  logic                       cram_rd,
  input  logic                       cram_wr,
  input  logic [7:0]                 cram_di,
  output logic [7:0]                 cram_do,
  output logic [RAM_BANK_BITS+12:0]  cram_addr,
  output logic [22:0]                mbc_addr,
  output logic                       cart_oe,
  output logic                       ram_enabled,
  output logic                       has_battery,
  output logic                       cap_busy,
  gb_camera_capture_if.master        pix
);

  typedef enum logic [2:0] {S_IDLE, S_EXPOSE, S_FETCH, S_WRITE, S_DONE} state_t;

  logic [ROM_BANK_BITS-1:0] rom_bank_q;
  logic [RAM_BANK_BITS-1:0] ram_bank_q;
  logic                     cam_en_q;
  logic                     ram_we_q;
  logic [1:0]               reg0_q;
  logic [7:0]               exp_hi_q;
  logic [7:0]               exp_lo_q;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [12:0] idx_q, idx_d;
  logic [7:0]  pix_q, pix_d;

  logic clr;
  logic mbc_wr;
  logic cam_wr;
  logic reg0_wr;
  logic start;
  logic abort;
  logic cap_wr_c;
  logic pix_req_c;
  logic [ROM_BANK_BITS-1:0] bank_m;

  assign clr     = reset | ~enable;
  assign mbc_wr  = cart_wr & ~cart_a15 & ce_cpu;
  assign cam_wr  = cam_en_q & cram_wr & ce_cpu;
  assign reg0_wr = cam_wr & (cart_addr[6:0] == 7'h00);
  assign start   = reg0_wr & cart_di[0];
  assign abort   = reg0_wr & ~cart_di[0];

  assign bank_m      = (cart_addr[14] ? rom_bank_q : '0) & rom_mask;
  assign mbc_addr    = {{(9 - ROM_BANK_BITS){1'b0}}, bank_m, cart_addr[13:0]};
  assign cram_addr   = {ram_bank_q & ram_mask, cart_addr[12:0]};
  assign cart_oe     = (cart_rd & ~cart_a15) | cram_rd;
  assign ram_enabled = ~cam_en_q & ram_we_q;
  assign has_battery = 1'b1;
  assign cap_busy    = (state_q == S_EXPOSE) || (state_q == S_FETCH) || (state_q == S_WRITE);

  always_comb begin
    cram_do = cram_di;
    if (cam_en_q) begin
      cram_do = (cart_addr[6:0] == 7'h00) ? {5'b0, reg0_q, cap_busy} : 8'h00;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (clr) begin
      rom_bank_q <= ROM_BANK_BITS'(1);
      ram_bank_q <= '0;
      cam_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      reg0_q     <= 2'b00;
      exp_hi_q   <= 8'h00;
      exp_lo_q   <= 8'h00;
    end else begin
      if (mbc_wr) begin
        case (cart_addr[14:13])
          2'b00: ram_we_q <= (cart_di[3:0] == 4'hA);
          2'b01: rom_bank_q <= cart_di[ROM_BANK_BITS-1:0];
          2'b10: begin
            if (cart_di[4]) begin
              cam_en_q <= 1'b1;
            end else begin
              cam_en_q   <= 1'b0;
              ram_bank_q <= cart_di[RAM_BANK_BITS-1:0];
            end
          end
          default: ;
        endcase
      end
      if (cam_wr) begin
        case (cart_addr[6:0])
          7'h00:   reg0_q   <= cart_di[2:1];
          7'h01:   exp_hi_q <= cart_di;
          7'h02:   exp_lo_q <= cart_di;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pix_d     = pix_q;
    pix_req_c = 1'b0;
    cap_wr_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EXPOSE;
          cnt_d   = 32'(CAP_BASE) + {12'b0, exp_hi_q, exp_lo_q, 4'b0};
          idx_d   = '0;
        end
      end
      // The tick that takes the counter to zero also moves on, so the first request follows the last tick.
      S_EXPOSE: begin
        if (cnt_q == 32'd0) begin
          state_d = S_FETCH;
        end else if (ce_cpu) begin
          cnt_d = cnt_q - 32'd1;
          if (cnt_q == 32'd1) state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pix_req_c = 1'b1;
        if (pix.pix_valid) begin
          pix_d   = pix.pix_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!(cram_rd || cram_wr)) begin
          cap_wr_c = 1'b1;
          idx_d    = idx_q + 13'd1;
          state_d  = (idx_q == 13'(FRAME_BYTES - 1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && cap_busy) state_d = S_IDLE;
  end

  assign pix.pix_req  = pix_req_c;
  assign pix.cap_wr   = cap_wr_c;
  assign pix.cap_addr = cap_wr_c ? {{RAM_BANK_BITS{1'b0}}, FRAME_BASE + idx_q} : '0;
  assign pix.cap_data = cap_wr_c ? pix_q : 8'h00;

endmodule

// File: tb/tb_gb_camera_capture.sv
// tb/tb_gb_camera_capture.sv - directed self-checking bench for gb_camera_capture
// Pixel source returns a running byte count; a write monitor checks address/data sequencing.
module tb_gb_camera_capture;
  logic        clk_sys = 1'b0;
  logic        reset, enable, ce_cpu;
  logic [5:0]  rom_mask;
  logic [3:0]  ram_mask;
  logic [14:0] cart_addr;
  logic        cart_a15, cart_rd, cart_wr;
  logic [7:0]  cart_di;
  logic        cram_rd, cram_wr;
  logic [7:0]  cram_di, cram_do;
  logic [16:0] cram_addr;
  logic [22:0] mbc_addr;
  logic        cart_oe, ram_enabled, has_battery, cap_busy;

  gb_camera_capture_if #(.RAM_BANK_BITS(4)) pif();

  gb_camera_capture dut (
    .clk_sys(clk_sys), .reset(reset), .enable(enable), .ce_cpu(ce_cpu),
    .rom_mask(rom_mask), .ram_mask(ram_mask), .cart_addr(cart_addr), .cart_a15(cart_a15),
    .cart_rd(cart_rd), .cart_wr(cart_wr), .cart_di(cart_di), .cram_rd(cram_rd),
    .cram_wr(cram_wr), .cram_di(cram_di), .cram_do(cram_do), .cram_addr(cram_addr),
    .mbc_addr(mbc_addr), .cart_oe(cart_oe), .ram_enabled(ram_enabled),
    .has_battery(has_battery), .cap_busy(cap_busy), .pix(pif)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  logic        pix_clr;
  logic [31:0] pix_cnt;
  logic        mon_clr;
  int          wr_cnt;
  int          seq_bad;
  logic [16:0] last_addr;
  logic [7:0]  last_data;

  assign pif.pix_data = pix_cnt[7:0];

  always @(posedge clk_sys) begin
    if (pix_clr) pix_cnt <= 32'd0;
    else if (pif.pix_req && pif.pix_valid) pix_cnt <= pix_cnt + 32'd1;
  end

  always @(posedge clk_sys) begin
    if (mon_clr) begin
      wr_cnt  <= 0;
      seq_bad <= 0;
    end else if (pif.cap_wr) begin
      if ((int'(pif.cap_addr) != 256 + wr_cnt) || (pif.cap_data !== wr_cnt[7:0]))
        seq_bad <= seq_bad + 1;
      last_addr <= pif.cap_addr;
      last_data <= pif.cap_data;
      wr_cnt    <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cart_addr = a[14:0];
    cart_a15  = a[15];
    cart_di   = d;
    if (a[15]) cram_wr = 1'b1;
    else       cart_wr = 1'b1;
    tick();
    cart_wr = 1'b0;
    cram_wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    cart_addr = a[14:0];
    cart_a15  = a[15];
    if (a[15]) cram_rd = 1'b1;
    else       cart_rd = 1'b1;
    #1;
  endtask

  task automatic rd_done();
    cart_rd = 1'b0;
    cram_rd = 1'b0;
  endtask

  int n;
  int base;
  bit stalled;

  initial begin
    reset = 1'b1; enable = 1'b1; ce_cpu = 1'b1;
    rom_mask = 6'h3F; ram_mask = 4'hF;
    cart_addr = '0; cart_a15 = 1'b0; cart_rd = 1'b0; cart_wr = 1'b0; cart_di = 8'h00;
    cram_rd = 1'b0; cram_wr = 1'b0; cram_di = 8'hA5;
    pif.pix_valid = 1'b0;
    pix_clr = 1'b1; mon_clr = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0; pix_clr = 1'b0; mon_clr = 1'b0;

    check("rst_cap_busy", cap_busy, 0);
    check("rst_pix_req", pif.pix_req, 0);
    check("rst_cap_wr", pif.cap_wr, 0);
    check("rst_cap_addr", pif.cap_addr, 0);
    check("rst_cap_data", pif.cap_data, 0);
    check("rst_ram_enabled", ram_enabled, 0);
    check("has_battery", has_battery, 1);
    cpu_rd(16'h4000);
    check("rst_mbc_addr", mbc_addr, 32'h04000);
    check("rom_cart_oe", cart_oe, 1);
    rd_done();
    cpu_rd(16'hA000);
    check("rst_cram_addr", cram_addr, 0);
    check("rst_cram_do", cram_do, 8'hA5);
    rd_done();

    cpu_wr(16'h2000, 8'h05);
    cpu_rd(16'h4000);
    check("rom_bank5", mbc_addr, 32'h14000);
    rom_mask = 6'h03;
    #1;
    check("rom_bank5_mask3", mbc_addr, 32'h04000);
    rom_mask = 6'h3F;
    rd_done();
    cpu_rd(16'h1234);
    check("rom_low_unbanked", mbc_addr, 32'h01234);
    rd_done();
    ce_cpu = 1'b0;
    cpu_wr(16'h2000, 8'h07);
    ce_cpu = 1'b1;
    cpu_rd(16'h4000);
    check("rom_wr_needs_ce", mbc_addr, 32'h14000);
    rd_done();
    cpu_wr(16'h2000, 8'h00);
    cpu_rd(16'h4000);
    check("rom_bank0_no_remap", mbc_addr, 32'h00000);
    rd_done();

    cpu_wr(16'h0000, 8'h0A);
    cpu_wr(16'h4000, 8'h03);
    cart_addr = 15'h2123; cart_a15 = 1'b1; cart_di = 8'h5A; cram_wr = 1'b1;
    #1;
    check("ram_enabled_on", ram_enabled, 1);
    check("cram_addr_bank3", cram_addr, 32'h06123);
    tick();
    cram_wr = 1'b0;
    cpu_wr(16'h4000, 8'h10);
    check("ram_enabled_cam", ram_enabled, 0);
    cpu_rd(16'hA005);
    check("cam_rd_other", cram_do, 8'h00);
    rd_done();
    cpu_rd(16'hA000);
    check("cam_rd_a000_idle", cram_do, 8'h00);
    rd_done();

    cpu_wr(16'hA001, 8'h00);
    cpu_wr(16'hA002, 8'h02);
    pif.pix_valid = 1'b1;
    cpu_wr(16'hA000, 8'h03);
    check("start_busy", cap_busy, 1);
    cpu_rd(16'hA000);
    check("cam_rd_a000_busy", cram_do, 8'h03);
    rd_done();
    n = 0;
    while (!pif.pix_req && n < 40000) begin
      tick();
      n++;
    end
    check("expose_ticks_exp2", n, 32478);

    stalled = 0;
    n = 0;
    while (cap_busy && n < 20000) begin
      if (!stalled && wr_cnt == 10 && pif.pix_req) begin
        base = wr_cnt;
        cart_addr = 15'h2000; cart_a15 = 1'b1; cram_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          check("stall_cap_wr", pif.cap_wr, 0);
        end
        cram_rd = 1'b0;
        #1;
        check("stall_release", pif.cap_wr, 1);
        tick();
        check("stall_single_write", wr_cnt, base + 1);
        stalled = 1;
        n += 4;
      end else begin
        tick();
        n++;
      end
    end
    check("frame_writes", wr_cnt, 3584);
    check("frame_seq_bad", seq_bad, 0);
    check("frame_last_addr", last_addr, 32'h00EFF);
    check("frame_last_data", last_data, 8'hFF);
    check("frame_pix_req_off", pif.pix_req, 0);
    cpu_rd(16'hA000);
    check("cam_rd_a000_done", cram_do, 8'h02);
    rd_done();

    tick();
    mon_clr = 1'b1; pix_clr = 1'b1;
    tick();
    mon_clr = 1'b0; pix_clr = 1'b0;
    cpu_wr(16'hA002, 8'h00);
    cpu_wr(16'hA000, 8'h01);
    n = 0;
    while (!pif.pix_req && n < 40000) begin
      if (n == 100) cpu_wr(16'hA000, 8'h01);
      else          tick();
      n++;
    end
    check("expose_ticks_exp0_restart_ignored", n, 32446);
    n = 0;
    while (wr_cnt < 100 && n < 1000) begin
      tick();
      n++;
    end
    cpu_wr(16'hA000, 8'h00);
    check("abort_busy", cap_busy, 0);
    check("abort_pix_req", pif.pix_req, 0);
    for (int k = 0; k < 5; k++) tick();
    check("abort_writes", wr_cnt, 100);
    check("abort_seq_bad", seq_bad, 0);

    cpu_wr(16'hA000, 8'h01);
    for (int k = 0; k < 10; k++) tick();
    check("expose_busy", cap_busy, 1);
    reset = 1'b1;
    tick();
    check("midrst_cap_busy", cap_busy, 0);
    check("midrst_pix_req", pif.pix_req, 0);
    check("midrst_cap_wr", pif.cap_wr, 0);
    check("midrst_cap_addr", pif.cap_addr, 0);
    check("midrst_cap_data", pif.cap_data, 0);
    check("midrst_ram_enabled", ram_enabled, 0);
    cpu_rd(16'hA000);
    check("midrst_cram_do", cram_do, 8'hA5);
    rd_done();
    cpu_rd(16'h4000);
    check("midrst_mbc_addr", mbc_addr, 32'h04000);
    rd_done();
    reset = 1'b0;
    tick();

    cpu_wr(16'h2000, 8'h05);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    cpu_rd(16'h4000);
    check("disable_clears_bank", mbc_addr, 32'h04000);
    rd_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
